// File: rtl/gcm_plaintext_gate.sv
// Release-on-verify buffer behind the AES-GCM decrypt stage: holds a plaintext frame until its tag verdict.
// Define GCM_GATE_ZEROIZE_EN to scrub every freed entry (popped words and the whole buffer on discard).
module gcm_plaintext_gate #(
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  input  logic                    auth_success,
  input  logic                    complete,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic                    done,
  output logic                    discarded,
  output logic                    overflow,
  output logic                    protocol_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RELEASE, S_DISCARD} state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             bad;
  logic             complete_q;
  logic [31:0]      mem [DEPTH];
`ifdef GCM_GATE_ZEROIZE_EN
  logic [PTR_W-1:0] zcnt;
`endif

  logic             verdict;
  logic             full;
  logic             accept;
  logic             drop_ovf;
  logic             frame_ok;
  logic             pop;
  logic             mem_we;
  logic [PTR_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;

  assign verdict   = complete & ~complete_q;
  assign full      = (level == LVL_W'(DEPTH));
  assign accept    = in_valid & ~full & ((state == S_IDLE) | (state == S_COLLECT));
  assign drop_ovf  = in_valid & full & (state == S_COLLECT);
  // A word overflowing in the verdict cycle already taints the frame it belongs to.
  assign frame_ok  = auth_success & ~bad & ~drop_ovf;
  assign out_valid = (state == S_RELEASE) && (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid & out_ready;
  assign busy      = (state != S_IDLE);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    mem_we    = accept;
    mem_addr  = wr_ptr;
    mem_wdata = in_data;
`ifdef GCM_GATE_ZEROIZE_EN
    if (state == S_RELEASE && pop) begin
      mem_we    = 1'b1;
      mem_addr  = rd_ptr;
      mem_wdata = '0;
    end else if (state == S_DISCARD) begin
      mem_we    = 1'b1;
      mem_wdata = '0;
    end
`endif
  end

  // NOTE: the storage array has no reset; occupancy is tracked by pointers and level, which do reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      bad          <= 1'b0;
      complete_q   <= 1'b0;
      done         <= 1'b0;
      discarded    <= 1'b0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
`ifdef GCM_GATE_ZEROIZE_EN
      zcnt         <= '0;
`endif
    end else begin
      complete_q <= complete;
      done       <= 1'b0;
      discarded  <= 1'b0;
      case (state)
        S_IDLE, S_COLLECT: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            level  <= level + 1'b1;
          end
          if (drop_ovf) begin
            overflow <= 1'b1;
            bad      <= 1'b1;
          end
          if (verdict && (state == S_COLLECT || in_valid)) begin
            if (frame_ok) begin
              state <= S_RELEASE;
            end else begin
              state <= S_DISCARD;
`ifdef GCM_GATE_ZEROIZE_EN
              zcnt <= '0;
`else
              discarded <= 1'b1;
`endif
            end
          end else if (verdict) begin
            // Zero-length frame: the verdict alone is reported.
            done      <= auth_success;
            discarded <= ~auth_success;
          end else if (in_valid) begin
            state <= S_COLLECT;
          end
        end
        S_RELEASE: begin
          if (in_valid) protocol_err <= 1'b1;
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            level  <= level - 1'b1;
          end
          if ((pop && level == LVL_W'(1)) || level == '0) begin
            done  <= 1'b1;
            bad   <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (in_valid) protocol_err <= 1'b1;
`ifdef GCM_GATE_ZEROIZE_EN
          // wr_ptr walks the whole ring once as the scrub address.
          wr_ptr <= wr_ptr + 1'b1;
          zcnt   <= zcnt + 1'b1;
          if (zcnt == PTR_W'(DEPTH - 1)) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            bad       <= 1'b0;
            discarded <= 1'b1;
            state     <= S_IDLE;
          end
`else
          wr_ptr <= '0;
          rd_ptr <= '0;
          level  <= '0;
          bad    <= 1'b0;
          state  <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_plaintext_gate.sv
// Self-checking bench for gcm_plaintext_gate: directed vector table, hand sequences, and random frames
// checked against a frame-level model (release iff authenticated and not longer than DEPTH).
module tb_gcm_plaintext_gate;
  localparam int DEPTH = 64;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             auth_success = 1'b0;
  logic             complete = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             out_valid;
  logic [LVL_W-1:0] level;
  logic             busy;
  logic             done;
  logic             discarded;
  logic             overflow;
  logic             protocol_err;

  gcm_plaintext_gate #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .auth_success(auth_success), .complete(complete), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .busy(busy),
    .done(done), .discarded(discarded), .overflow(overflow), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: collects handshaken words and pulse counts, and checks stall stability.
  logic [31:0] got_q[$];
  int          done_cnt = 0;
  int          disc_cnt = 0;
  int          cyc = 0;
  int          last_hs_cyc = -1;
  int          done_cyc = -1;
  logic        stalled = 1'b0;
  logic [31:0] stall_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, stall_data);
      end
      if (!out_valid) check("out_data_zero_when_invalid", out_data, 0);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (discarded) disc_cnt++;
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // Stimulus: inputs change 1 time unit after the rising edge.
  logic [0:4]  pat = 5'b10011;
  int          pat_i = 0;
  int          ready_mode = 0;
  logic [31:0] tx_q[$];
  logic        first_valid;

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (pat_i < 5) ? pat[pat_i] : 1'b1;
        pat_i++;
      end
    endcase
  endtask

  task automatic send_frame(input bit auth, input bit simul);
    for (int i = 0; i < tx_q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = tx_q[i];
      if (simul && i == tx_q.size() - 1) begin
        complete     = 1'b1;
        auth_success = auth;
        pat_i        = 0;
      end
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (!simul || tx_q.size() == 0) begin
      complete     = 1'b1;
      auth_success = auth;
      pat_i        = 0;
      step();
    end
    complete     = 1'b0;
    auth_success = 1'b0;
    @(negedge clk);
    first_valid = out_valid;
  endtask

  task automatic wait_idle(input int tag);
    int n = 0;
    while (busy && n < 400) begin
      step();
      n++;
      @(negedge clk);
    end
    check($sformatf("f%0d_idle_within_budget", tag), (n < 400), 1);
    step();
    step();
  endtask

  task automatic check_frame(input int tag, input int exp_words, input int exp_done,
                             input int exp_disc, input bit exp_ovf);
    wait_idle(tag);
    check($sformatf("f%0d_word_count", tag), got_q.size(), exp_words);
    for (int i = 0; i < exp_words && i < got_q.size(); i++)
      check($sformatf("f%0d_word%0d", tag, i), got_q[i], tx_q[i]);
    check($sformatf("f%0d_done_pulses", tag), done_cnt, exp_done);
    check($sformatf("f%0d_discard_pulses", tag), disc_cnt, exp_disc);
    if (exp_done != 0 && exp_words > 0)
      check($sformatf("f%0d_done_after_last", tag), done_cyc, last_hs_cyc + 1);
    check($sformatf("f%0d_level", tag), level, 0);
    check($sformatf("f%0d_overflow", tag), overflow, exp_ovf);
  endtask

  task automatic run_frame(input int tag, input int len, input logic [31:0] base, input bit auth,
                           input bit simul, input int rmode, input int exp_words,
                           input int exp_done, input int exp_disc, input bit exp_ovf);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(base + 32'(i) * 32'h11);
    got_q.delete();
    done_cnt    = 0;
    disc_cnt    = 0;
    done_cyc    = -1;
    last_hs_cyc = -1;
    ready_mode  = rmode;
    send_frame(auth, simul);
    check($sformatf("f%0d_valid_after_verdict", tag), first_valid, (exp_words > 0));
    check_frame(tag, exp_words, exp_done, exp_disc, exp_ovf);
  endtask

  typedef struct {
    int          len;
    logic [31:0] base;
    bit          auth;
    bit          simul;
    int          rmode;
    int          exp_words;
    int          exp_done;
    int          exp_disc;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[8];
  bit   model_ovf;

  initial begin
    vecs[0] = '{4,         32'h0000_0011, 1'b1, 1'b0, 0, 4,     1, 0, 1'b0}; // pass frame
    vecs[1] = '{3,         32'h0000_0100, 1'b0, 1'b0, 0, 0,     0, 1, 1'b0}; // auth fail
    vecs[2] = '{3,         32'hA5A5_0000, 1'b1, 1'b0, 2, 3,     1, 0, 1'b0}; // backpressure 1,0,0,1,1
    vecs[3] = '{0,         32'h0,         1'b1, 1'b0, 0, 0,     1, 0, 1'b0}; // empty, verified
    vecs[4] = '{0,         32'h0,         1'b0, 1'b0, 0, 0,     0, 1, 1'b0}; // empty, rejected
    vecs[5] = '{2,         32'h0000_5000, 1'b1, 1'b1, 0, 2,     1, 0, 1'b0}; // last word with verdict
    vecs[6] = '{DEPTH,     32'hC0DE_0000, 1'b1, 1'b0, 1, DEPTH, 1, 0, 1'b0}; // exactly full
    vecs[7] = '{DEPTH + 2, 32'h0000_7000, 1'b1, 1'b0, 0, 0,     0, 1, 1'b1}; // overflow

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_discarded", discarded, 0);
    check("rst_overflow", overflow, 0);
    check("rst_protocol_err", protocol_err, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    for (int v = 0; v < 8; v++)
      run_frame(v, vecs[v].len, vecs[v].base, vecs[v].auth, vecs[v].simul, vecs[v].rmode,
                vecs[v].exp_words, vecs[v].exp_done, vecs[v].exp_disc, vecs[v].exp_ovf);

`ifdef GCM_GATE_ZEROIZE_EN
    begin
      logic [31:0] acc = '0;
      for (int i = 0; i < DEPTH; i++) acc |= dut.mem[i];
      check("zeroized_memory_or", acc, 0);
    end
`endif

    // Word arriving during RELEASE is dropped and flagged; the frame still drains intact.
    check("perr_before", protocol_err, 0);
    tx_q.delete();
    for (int i = 0; i < 3; i++) tx_q.push_back(32'h0BAD_0000 + 32'(i));
    got_q.delete();
    done_cnt = 0; disc_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    ready_mode = 0;
    send_frame(1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    check_frame(10, 3, 1, 0, 1'b1);
    check("perr_set", protocol_err, 1);

    // Reset after one of four words has been popped.
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(32'h0000_0900 + 32'(i));
    got_q.delete();
    ready_mode = 0;
    send_frame(1'b1, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    check("midrst_popped_one", got_q.size(), 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_level", level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_discarded", discarded, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_protocol_err", protocol_err, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    run_frame(20, 1, 32'h0000_600D, 1'b1, 1'b0, 0, 1, 1, 0, 1'b0);

    // Random frames against the frame-level model.
    model_ovf = 1'b0;
    for (int r = 0; r < 24; r++) begin
      int          len;
      bit          auth;
      bit          simul;
      bit          too_long;
      bit          released;
      logic [31:0] base;
      len      = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH - 1, DEPTH + 2))
                                             : int'($urandom_range(0, 10));
      auth     = 1'($urandom_range(0, 1));
      simul    = 1'($urandom_range(0, 1));
      base     = $urandom;
      too_long = (len > DEPTH);
      released = auth && !too_long;
      model_ovf = model_ovf | too_long;
      run_frame(100 + r, len, base, auth, simul, 1, released ? len : 0,
                released ? 1 : 0, released ? 0 : 1, model_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gcm_plaintext_gate.md
# gcm_plaintext_gate

Release-on-verify buffer that sits directly downstream of the AES-GCM decrypt stage in the security agent. It captures each decrypted 32-bit plaintext word as it is produced and holds the whole frame. It forwards the frame to the consumer over a valid/ready interface only after the frame's authentication verdict is positive. Frames that fail authentication or overflow the buffer are flushed without ever reaching the consumer.

## Interface
- DEPTH, 64, buffer capacity in 32-bit words; power of two, ≥ 4
- clk  in  1  clock; all logic on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- in_data  in  32  plaintext word from decrypt stage
- in_valid  in  1  single-cycle strobe; in_data is valid this cycle; no backpressure toward the decrypt stage
- auth_success  in  1  level from decrypt stage; sampled only on the verdict edge
- complete  in  1  level from decrypt stage; its rising edge is the frame verdict edge
- out_data  out  32  word to consumer; 0 whenever out_valid = 0
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word when out_valid & out_ready
- level  out  $clog2(DEPTH)+1  words currently held
- busy  out  1  high in COLLECT, RELEASE or DISCARD
- done  out  1  one-cycle pulse: frame fully released, or zero-length frame verified
- discarded  out  1  one-cycle pulse: frame dropped
- overflow  out  1  sticky; a word arrived while the buffer was full
- protocol_err  out  1  sticky; in_valid arrived in RELEASE or DISCARD

## Operation
- Reset values: out_data 0, out_valid 0, level 0, busy 0, done 0, discarded 0, overflow 0, protocol_err 0, state IDLE, pointers 0, bad flag 0. Memory contents are not reset.
- The verdict edge is `complete & !complete_q`. complete_q is a registered copy of complete and resets to 0.
- IDLE:
  - in_valid: write the word and go to COLLECT.
  - Verdict edge with in_valid = 0 (zero-length frame): pulse done if auth_success is high, otherwise pulse discarded. Stay in IDLE.
- COLLECT:
  - in_valid with level < DEPTH: write to mem[wr_ptr], increment wr_ptr (wraps modulo DEPTH), increment level.
  - in_valid with level = DEPTH: drop the word, set overflow, set bad.
  - Verdict edge: go to RELEASE if auth_success & !bad; otherwise go to DISCARD.
  - in_valid and verdict edge in the same cycle: the word is written (or overflows) first, and the verdict applies to the frame including that word.
- RELEASE:
  - out_valid = (level != 0), out_data = mem[rd_ptr].
  - On out_valid & out_ready: increment rd_ptr (wraps) and decrement level.
  - When the last word is popped: pulse done next cycle, clear bad, return to IDLE.
  - in_valid: drop the word, set protocol_err.
- DISCARD (without macro): one cycle. Clear pointers and level, clear bad, pulse discarded, return to IDLE. in_valid here is dropped and sets protocol_err.
- Pointers are $clog2(DEPTH) bits. level is $clog2(DEPTH)+1 bits, so level = DEPTH is representable. Write and read never occur together, because they belong to disjoint states.
- overflow and protocol_err clear only on reset.

## Timing
- Verdict edge sampled at edge N: state is RELEASE at N+1, with out_valid high in that cycle if level > 0.
- Sustained throughput in RELEASE is 1 word per cycle with out_ready held high. A frame of L words drains in L cycles. done is high in the cycle after the final handshake.
- out_data and out_valid are stable while out_valid & !out_ready.
- DISCARD without macro: discarded is high at N+1 and state is IDLE at N+2.
- The decrypt stage must not start a new frame until busy is low. Words violating this are dropped and flagged as above.
- reset_n asserted in any state: immediate return to reset values, and any held frame is lost.

## Configuration
- GCM_GATE_ZEROIZE_EN defined:
  - DISCARD lasts DEPTH cycles and writes 32'h0 to mem[0..DEPTH-1], one entry per cycle, before pulsing discarded.
  - Release from RELEASE also zeroizes each entry as it is popped.
- Undefined: DISCARD takes one cycle, only pointers are cleared, and stale data remains in memory.

## Test plan
- Pass frame: 4 words 0x11,0x22,0x33,0x44, then complete↑ with auth_success = 1 and out_ready = 1. Required: out_valid from the cycle after the verdict, words in order over 4 cycles, done pulse, level 0.
- Fail frame: 3 words, then complete↑ with auth_success = 0. Required: out_valid never asserts, discarded pulse, level 0. With the macro, memory reads back all 0 after DEPTH cycles.
- Backpressure: pass frame of 3 words with out_ready toggling 1,0,0,1,1. Required: out_data held constant while stalled, exactly 3 handshakes.
- Overflow: DEPTH+2 words, then complete↑ with auth_success = 1. Required: overflow = 1, discarded pulse, no output.
- Simultaneous: 2nd word and complete↑ in the same cycle with auth_success = 1. Required: 2 words released. Then an in_valid during RELEASE sets protocol_err without corrupting the output.
- Reset mid-RELEASE: assert reset_n low after 1 of 4 words has been popped. Required: all outputs at reset values and IDLE; a following 1-word pass frame releases correctly.
